// File: rtl/pwm_deadtime.sv
// Dead-time inserter: splits one PWM stream into non-overlapping high-side and low-side gate drives.
// Optional fault latch (fault, fault_clr, fault_flag, FAULT state) is built when PWM_DT_FAULT_EN is defined.
module pwm_deadtime #(
    parameter int DT_BITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               pwm_in,
    input  logic [DT_BITS-1:0] dead_time,
`ifdef PWM_DT_FAULT_EN
    input  logic               fault,
    input  logic               fault_clr,
    output logic               fault_flag,
`endif
    output logic               pwm_hi,
    output logic               pwm_lo,
    output logic               dt_active
);

    typedef enum logic [2:0] {
        OFF,
        DT_H,
        HI,
        DT_L,
`ifdef PWM_DT_FAULT_EN
        LO,
        FAULT
`else
        LO
`endif
    } state_t;

    localparam logic [DT_BITS-1:0] CNT_ONE = DT_BITS'(1);

    state_t             state_q, state_d;
    logic [DT_BITS-1:0] cnt_q, cnt_d;
    logic               in_q, in_d;
    logic               pwm_hi_q, pwm_hi_d;
    logic               pwm_lo_q, pwm_lo_d;
    logic               dt_active_q, dt_active_d;
`ifdef PWM_DT_FAULT_EN
    logic               fault_flag_q, fault_flag_d;
`endif

    logic               dt_zero;
    logic [DT_BITS-1:0] dt_load;

    // dead_time is only looked at here, on entry to a band, so later changes cannot stretch a running band.
    assign dt_zero = (dead_time == '0);
    assign dt_load = dead_time - CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in_d    = pwm_in;

        case (state_q)
            OFF: begin
                if (in_q) begin
                    if (dt_zero) begin
                        state_d = HI;
                    end else begin
                        state_d = DT_H;
                        cnt_d   = dt_load;
                    end
                end else begin
                    if (dt_zero) begin
                        state_d = LO;
                    end else begin
                        state_d = DT_L;
                        cnt_d   = dt_load;
                    end
                end
            end
            LO: begin
                if (in_q) begin
                    if (dt_zero) begin
                        state_d = HI;
                    end else begin
                        state_d = DT_H;
                        cnt_d   = dt_load;
                    end
                end
            end
            // A revert during a band goes straight back: the side being waited for was never switched on.
            DT_H: begin
                if (!in_q) begin
                    state_d = LO;
                end else if (cnt_q == '0) begin
                    state_d = HI;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HI: begin
                if (!in_q) begin
                    if (dt_zero) begin
                        state_d = LO;
                    end else begin
                        state_d = DT_L;
                        cnt_d   = dt_load;
                    end
                end
            end
            DT_L: begin
                if (in_q) begin
                    state_d = HI;
                end else if (cnt_q == '0) begin
                    state_d = LO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`ifdef PWM_DT_FAULT_EN
            FAULT: begin
                if (fault_clr && !fault) begin
                    state_d = OFF;
                end
            end
`endif
            default: begin
                state_d = OFF;
            end
        endcase

`ifdef PWM_DT_FAULT_EN
        // A latched fault ignores enable; only fault_clr may release it.
        if (!enable && (state_q != FAULT)) begin
            state_d = OFF;
        end
        if (fault) begin
            state_d = FAULT;
        end
`else
        if (!enable) begin
            state_d = OFF;
        end
`endif
    end

    // Output flops decode the next state, so both drives come from one state value and can never overlap.
    always_comb begin
        pwm_hi_d    = (state_d == HI);
        pwm_lo_d    = (state_d == LO);
        dt_active_d = (state_d == DT_H) || (state_d == DT_L);
`ifdef PWM_DT_FAULT_EN
        fault_flag_d = (state_d == FAULT);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= OFF;
            cnt_q       <= '0;
            in_q        <= 1'b0;
            pwm_hi_q    <= 1'b0;
            pwm_lo_q    <= 1'b0;
            dt_active_q <= 1'b0;
`ifdef PWM_DT_FAULT_EN
            fault_flag_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_q        <= in_d;
            pwm_hi_q    <= pwm_hi_d;
            pwm_lo_q    <= pwm_lo_d;
            dt_active_q <= dt_active_d;
`ifdef PWM_DT_FAULT_EN
            fault_flag_q <= fault_flag_d;
`endif
        end
    end

    assign pwm_hi    = pwm_hi_q;
    assign pwm_lo    = pwm_lo_q;
    assign dt_active = dt_active_q;
`ifdef PWM_DT_FAULT_EN
    assign fault_flag = fault_flag_q;
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: directed steps plus randomized traffic against a band-countdown model.
// Fault coverage is included when PWM_DT_FAULT_EN is defined.
module tb_pwm_deadtime;

    localparam int DT_BITS = 4;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic               pwm_in;
    logic [DT_BITS-1:0] dead_time;
    logic               pwm_hi;
    logic               pwm_lo;
    logic               dt_active;
`ifdef PWM_DT_FAULT_EN
    logic               fault;
    logic               fault_clr;
    logic               fault_flag;
`endif

    int errors = 0;
    int checks = 0;

    // Model: which side is wanted, how many band cycles remain before it is driven, and whether driving at all.
    logic m_inq, m_active, m_want, m_faulted;
    int   m_left;

    pwm_deadtime #(.DT_BITS(DT_BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .pwm_in    (pwm_in),
        .dead_time (dead_time),
`ifdef PWM_DT_FAULT_EN
        .fault     (fault),
        .fault_clr (fault_clr),
        .fault_flag(fault_flag),
`endif
        .pwm_hi    (pwm_hi),
        .pwm_lo    (pwm_lo),
        .dt_active (dt_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic old;
        if (!rst_n) begin
            m_inq = 1'b0; m_active = 1'b0; m_want = 1'b0; m_left = 0; m_faulted = 1'b0;
            return;
        end
        old   = m_inq;
        m_inq = pwm_in;
`ifdef PWM_DT_FAULT_EN
        if (fault) begin
            m_faulted = 1'b1; m_active = 1'b0;
            return;
        end
        if (m_faulted) begin
            if (fault_clr) m_faulted = 1'b0;
            return;
        end
`endif
        if (!enable) begin
            m_active = 1'b0;
            return;
        end
        if (!m_active) begin
            m_active = 1'b1; m_want = old; m_left = int'(dead_time);
        end else if (old != m_want) begin
            m_left = (m_left == 0) ? int'(dead_time) : 0;
            m_want = old;
        end else if (m_left > 0) begin
            m_left--;
        end
    endtask

    task automatic check_output();
        check_bit("pwm_hi", pwm_hi, m_active && (m_left == 0) && m_want);
        check_bit("pwm_lo", pwm_lo, m_active && (m_left == 0) && !m_want);
        check_bit("dt_active", dt_active, m_active && (m_left > 0));
        check_bit("no_overlap", pwm_hi && pwm_lo, 1'b0);
`ifdef PWM_DT_FAULT_EN
        check_bit("fault_flag", fault_flag, m_faulted);
`endif
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        model_edge();
        #1;
        check_output();
    endtask

    initial begin
        int dt_cnt, band_len, bands, gen_cnt, duty, last, cur, run_len;
        logic hi_seen, dt_seen, hi_drop;

        rst_n = 1'b0; enable = 1'b0; pwm_in = 1'b1; dead_time = 4'd3;
`ifdef PWM_DT_FAULT_EN
        fault = 1'b0; fault_clr = 1'b0;
`endif
        m_inq = 1'b0; m_active = 1'b0; m_want = 1'b0; m_left = 0; m_faulted = 1'b0;

        // Reset with pwm_in high, then enable into a 3-cycle band.
        apply_stimulus();
        check_bit("rst_hi", pwm_hi, 1'b0);
        check_bit("rst_lo", pwm_lo, 1'b0);
        check_bit("rst_dt", dt_active, 1'b0);
        rst_n = 1'b1;
        apply_stimulus();
        enable = 1'b1;
        dt_cnt = 0;
        for (int i = 0; i < 12 && !pwm_hi; i++) begin
            apply_stimulus();
            if (dt_active) dt_cnt++;
        end
        check_int("rst_band_len", dt_cnt, 3);
        check_bit("rst_then_hi", pwm_hi, 1'b1);

        // 50% PWM from an 8-bit generator, dead_time=5.
        dead_time = 4'd5; duty = 128; gen_cnt = 0; band_len = 0; bands = 0;
        for (int i = 0; i < 768; i++) begin
            pwm_in  = (gen_cnt < duty);
            gen_cnt = (gen_cnt + 1) % 256;
            apply_stimulus();
            if (pwm_hi || pwm_lo) begin
                if (band_len > 0) begin
                    check_int("band_len", band_len, 5);
                    bands++;
                end
                band_len = 0;
            end else begin
                band_len++;
            end
        end
        check_bit("bands_seen", bands >= 5, 1'b1);

        // Short pulse aborts a long band.
        pwm_in = 1'b0; dead_time = 4'd8;
        for (int i = 0; i < 20; i++) apply_stimulus();
        check_bit("abort_pre_lo", pwm_lo, 1'b1);
        hi_seen = 1'b0; dt_seen = 1'b0;
        pwm_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            if (pwm_hi) hi_seen = 1'b1;
            if (dt_active) dt_seen = 1'b1;
        end
        pwm_in = 1'b0;
        for (int i = 0; i < 15; i++) begin
            apply_stimulus();
            if (pwm_hi) hi_seen = 1'b1;
        end
        check_bit("abort_no_hi", hi_seen, 1'b0);
        check_bit("abort_band_started", dt_seen, 1'b1);
        check_bit("abort_back_lo", pwm_lo, 1'b1);

        // dead_time=0: outputs follow pwm_in two edges late, complementary.
        dead_time = 4'd0; last = 0;
        for (int i = 0; i < 100; i++) begin
            cur = int'($urandom_range(0, 1));
            pwm_in = cur[0];
            apply_stimulus();
            check_bit("dt0_hi", pwm_hi, last[0]);
            check_bit("dt0_lo", pwm_lo, !last[0]);
            last = cur;
        end

        // 100% duty holds HI after one start-up band.
        dead_time = 4'd4; duty = 256; hi_seen = 1'b0; hi_drop = 1'b0; dt_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            pwm_in = (gen_cnt < duty);
            gen_cnt = (gen_cnt + 1) % 256;
            apply_stimulus();
            if (hi_seen && dt_active) dt_cnt++;
            if (hi_seen && !pwm_hi) hi_drop = 1'b1;
            if (pwm_hi) hi_seen = 1'b1;
        end
        check_bit("full_hi_seen", hi_seen, 1'b1);
        check_bit("full_hi_held", hi_drop, 1'b0);
        check_int("full_no_band", dt_cnt, 0);

        // Enable drop from HI, then re-enable with a 2-cycle band.
        enable = 1'b0;
        apply_stimulus();
        check_bit("en_off_hi", pwm_hi, 1'b0);
        check_bit("en_off_lo", pwm_lo, 1'b0);
        dead_time = 4'd2; enable = 1'b1; dt_cnt = 0;
        for (int i = 0; i < 12 && !pwm_hi; i++) begin
            apply_stimulus();
            if (dt_active) dt_cnt++;
        end
        check_int("en_band_len", dt_cnt, 2);
        check_bit("en_then_hi", pwm_hi, 1'b1);

`ifdef PWM_DT_FAULT_EN
        // Fault pulse from LO latches until cleared, then a fresh band.
        pwm_in = 1'b0; dead_time = 4'd3;
        for (int i = 0; i < 10; i++) apply_stimulus();
        check_bit("flt_pre_lo", pwm_lo, 1'b1);
        fault = 1'b1;
        apply_stimulus();
        check_bit("flt_flag_set", fault_flag, 1'b1);
        check_bit("flt_lo_off", pwm_lo, 1'b0);
        fault = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus();
        check_bit("flt_flag_held", fault_flag, 1'b1);
        fault_clr = 1'b1;
        apply_stimulus();
        check_bit("flt_flag_clr", fault_flag, 1'b0);
        fault_clr = 1'b0; dt_cnt = 0;
        for (int i = 0; i < 12 && !pwm_lo; i++) begin
            apply_stimulus();
            if (dt_active) dt_cnt++;
        end
        check_int("flt_band_len", dt_cnt, 3);
        check_bit("flt_then_lo", pwm_lo, 1'b1);
`endif

        // Randomized traffic: varying run lengths, dead_time changes mid-band, enable drops, resets.
        run_len = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_len == 0) begin
                pwm_in  = 1'($urandom_range(0, 1));
                run_len = int'($urandom_range(1, 20));
            end
            run_len--;
            if ($urandom_range(0, 30) == 0) dead_time = DT_BITS'($urandom_range(0, 15));
            enable = ($urandom_range(0, 99) != 0);
            rst_n  = ($urandom_range(0, 199) != 0);
`ifdef PWM_DT_FAULT_EN
            fault     = ($urandom_range(0, 299) == 0);
            fault_clr = ($urandom_range(0, 9) == 0);
`endif
            apply_stimulus();
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
